dual_priority_decoder: RTL and testbench



---
 rtl/dual_priority_decoder_pkg.sv | 10 +
 rtl/dual_priority_decoder_onehot.sv | 13 +
 rtl/dual_priority_decoder.sv | 73 +++++++
 tb/tb_dual_priority_decoder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dual_priority_decoder_pkg.sv
// dual_priority_decoder_pkg: shared FSM encodings and default sizing for the dual priority decoder
package dual_priority_decoder_pkg;
  localparam int N_DEF = 12;
  localparam int W_DEF = 4;
  localparam int HOLD_DEF = 4;
  localparam int NONE = 0;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
endpackage

// File: rtl/dual_priority_decoder_onehot.sv
// dpd_onehot: code k -> bit k-1; code 0 and codes above N give an empty mask
module dpd_onehot #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [W-1:0] code_i,
  output logic [N-1:0] mask_o
);
  always_comb begin
    mask_o = '0;
    for (int i = 0; i < N; i++) mask_o[i] = (code_i == W'(i + 1));
  end
endmodule

// File: rtl/dual_priority_decoder.sv
// dual_priority_decoder: decodes a (first, second) code pair into a held grant mask, then strobes done.
// Define DUAL_PRIORITY_DECODER_ERR_EN to enable the sticky illegal-pair err flag.
module dual_priority_decoder
  import dual_priority_decoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] first,
  input  logic [W-1:0] second,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         done,
  output logic         err
);
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [N-1:0] grant_q, grant_d, mask_f, mask_s;
  logic accept, empty;
  dpd_onehot #(.N(N), .W(W)) u_first (.code_i(first), .mask_o(mask_f));
  dpd_onehot #(.N(N), .W(W)) u_second (.code_i(second), .mask_o(mask_s));
  assign in_ready = state_q == IDLE;
  assign grant_valid = state_q == GRANT;
  assign done = state_q == RELEASE;
  assign grant = grant_q;
  assign accept = in_valid && in_ready;
  assign empty = first == W'(NONE) && second == W'(NONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    if (accept) begin
      state_d = empty ? RELEASE : GRANT;
      cnt_d = empty ? cnt_q : 8'(HOLD - 1);
      grant_d = mask_f | mask_s;
    end else if (state_q == GRANT) begin
      state_d = cnt_q == 8'd0 ? RELEASE : GRANT;
      cnt_d = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
      grant_d = cnt_q == 8'd0 ? '0 : grant_q;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
    end
  end
`ifdef DUAL_PRIORITY_DECODER_ERR_EN
  logic err_q, illegal;
  // legal: both codes in range, and second strictly below first (or both empty when first is 0)
  assign illegal = first > W'(N) || second > W'(N) ||
                   (first != W'(NONE) ? second >= first : second != W'(NONE));
  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else if (accept) err_q <= illegal;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_dual_priority_decoder.sv
// tb_dual_priority_decoder: table-driven scoreboard bench for dual_priority_decoder
module tb_dual_priority_decoder;
  localparam int HOLD = 4;
`ifdef DUAL_PRIORITY_DECODER_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif
  typedef struct {
    logic [3:0]  f;
    logic [3:0]  s;
    logic [11:0] g;
    logic        e;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0;
  logic [3:0] first = '0, second = '0;
  logic in_ready, grant_valid, done, err;
  logic [11:0] grant;
  vec_t q[$];
  vec_t tbl[11];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dual_priority_decoder #(.N(12), .W(4), .HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .first(first), .second(second), .grant(grant), .grant_valid(grant_valid),
    .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic wait_ready;
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask
  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    first = v.f;
    second = v.s;
    q.push_back(v);
  endtask
  task automatic check_txn;
    vec_t v;
    if (q.size() == 0) begin
      chk("queue_empty", 32'(q.size()), 32'd1);
      return;
    end
    v = q.pop_front();
    if (!(v.f == 4'd0 && v.s == 4'd0))
      for (int k = 1; k <= HOLD; k++) begin
        @(negedge clk);
        chk($sformatf("grant_%0h_%0h_c%0d", v.f, v.s, k), 32'(grant), 32'(v.g));
        chk("grant_valid", 32'(grant_valid), 32'd1);
        chk("busy_ready", 32'(in_ready), 32'd0);
        chk("early_done", 32'(done), 32'd0);
        chk("err", 32'(err), 32'(v.e));
      end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("rel_gv", 32'(grant_valid), 32'd0);
    chk("rel_grant", 32'(grant), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd0);
    chk("rel_err", 32'(err), 32'(v.e));
    @(negedge clk);
    chk("ready_back", 32'(in_ready), 32'd1);
    chk("done_drop", 32'(done), 32'd0);
  endtask
  initial begin
    tbl[0] = '{4'd12, 4'd9, 12'h900, 1'b0};
    tbl[1] = '{4'd0, 4'd0, 12'h000, 1'b0};
    tbl[2] = '{4'd13, 4'd0, 12'h000, EE};
    tbl[3] = '{4'd5, 4'd3, 12'h014, 1'b0};
    tbl[4] = '{4'd5, 4'd7, 12'h050, EE};
    tbl[5] = '{4'd1, 4'd0, 12'h001, 1'b0};
    tbl[6] = '{4'd12, 4'd12, 12'h800, EE};
    tbl[7] = '{4'd0, 4'd5, 12'h010, EE};
    tbl[8] = '{4'd15, 4'd15, 12'h000, EE};
    tbl[9] = '{4'd12, 4'd11, 12'hC00, 1'b0};
    tbl[10] = '{4'd3, 4'd2, 12'h006, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 11; i++) begin
      wait_ready();
      drive(tbl[i]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      check_txn();
    end
    // back-to-back: second pair waits with in_valid high until the first completes
    wait_ready();
    drive('{4'd12, 4'd10, 12'hA00, 1'b0});
    @(posedge clk);
    #1 drive('{4'd2, 4'd1, 12'h003, 1'b0});
    check_txn();
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_txn();
    // reset during the second GRANT cycle aborts without a done pulse
    wait_ready();
    drive('{4'd12, 4'd9, 12'h900, 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_g1", 32'(grant), 32'h900);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_gv", 32'(grant_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < HOLD + 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(in_ready), 32'd1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
